// File: rtl/ysyx_23060187_pkg.sv
// Shared encodings and types for the load/store unit.
// Combinational definitions only; no latency or backpressure of its own.
package ysyx_23060187_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Only the parts of the access still needed after the request has been issued.
    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] off;
    } lsu_req_t;

endpackage

// File: rtl/ysyx_23060187_lsu_align.sv
// Byte-lane steering: store replication and strobes, load extract and extend, illegal/misaligned detect.
// Latency: purely combinational.
// Backpressure: none; the enclosing FSM decides when the outputs are used.
module ysyx_23060187_lsu_align
    import ysyx_23060187_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [31:0] shifted;

    always_comb begin
        shifted  = rdata >> {off, 3'b000};
        st_wdata = wdata;
        st_wstrb = 4'hF;
        ld_data  = rdata;
        misalign = 1'b0;
        // misalign also covers funct3 codes that are illegal for the access type
        case (funct3)
            F3_B: begin
                st_wdata = {4{wdata[7:0]}};
                st_wstrb = 4'b0001 << off;
                ld_data  = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H: begin
                st_wdata = {2{wdata[15:0]}};
                st_wstrb = 4'b0011 << off;
                ld_data  = {{16{shifted[15]}}, shifted[15:0]};
                misalign = off[0];
            end
            F3_W: begin
                misalign = (off != 2'b00);
            end
            F3_BU: begin
                ld_data  = {24'd0, shifted[7:0]};
                misalign = is_store;
            end
            F3_HU: begin
                ld_data  = {16'd0, shifted[15:0]};
                misalign = is_store | off[0];
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060187_lsu.sv
// Single-outstanding load/store unit between EX and a word-wide valid/ready memory bus.
// Latency: accept->out_valid = 3 cycles on a zero-wait bus, 1 for rejected access, TIMEOUT_CYC+1 on timeout.
// Backpressure: in_ready only in IDLE; request held stable until mem_req_ready.
module ysyx_23060187_lsu
    import ysyx_23060187_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_rdata,
    output logic        out_misalign,
    output logic        out_timeout
);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYC);

    lsu_state_t  state;
    lsu_req_t    req;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;

    logic        a_is_store;
    logic [2:0]  a_funct3;
    logic [1:0]  a_off;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;
    logic        misalign;

    // One aligner serves both phases: the incoming access while IDLE, the latched one afterwards.
    always_comb begin
        a_is_store = req.is_store;
        a_funct3   = req.funct3;
        a_off      = req.off;
        if (state == ST_IDLE) begin
            a_is_store = in_is_store;
            a_funct3   = in_funct3;
            a_off      = in_addr[1:0];
        end
    end

    assign cnt_inc = cnt + 16'd1;

    ysyx_23060187_lsu_align u_align (
        .is_store (a_is_store),
        .funct3   (a_funct3),
        .off      (a_off),
        .wdata    (in_wdata),
        .rdata    (mem_rdata),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_data  (ld_data),
        .misalign (misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            req           <= '0;
            cnt           <= '0;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            out_valid     <= 1'b0;
            out_rdata     <= '0;
            out_misalign  <= 1'b0;
            out_timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        req      <= '{is_store: in_is_store, funct3: in_funct3, off: in_addr[1:0]};
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        if (misalign) begin
                            state        <= ST_DONE;
                            out_valid    <= 1'b1;
                            out_misalign <= 1'b1;
                            out_rdata    <= '0;
                        end else begin
                            state         <= ST_REQ;
                            mem_req_valid <= 1'b1;
                            mem_we        <= in_is_store;
                            mem_addr      <= {in_addr[31:2], 2'b00};
                            mem_wdata     <= in_is_store ? st_wdata : 32'd0;
                            mem_wstrb     <= in_is_store ? st_wstrb : 4'd0;
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt_inc;
                    if (cnt_inc == TMO) begin
                        state         <= ST_DONE;
                        mem_req_valid <= 1'b0;
                        out_valid     <= 1'b1;
                        out_timeout   <= 1'b1;
                        out_rdata     <= '0;
                    end else if (mem_req_ready) begin
                        state         <= ST_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt_inc;
                    // A response arriving on the last allowed cycle still wins over the abort.
                    if (mem_resp_valid) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out_rdata <= req.is_store ? 32'd0 : ld_data;
                    end else if (cnt_inc == TMO) begin
                        state       <= ST_DONE;
                        out_valid   <= 1'b1;
                        out_timeout <= 1'b1;
                        out_rdata   <= '0;
                    end
                end
                ST_DONE: begin
                    state        <= ST_IDLE;
                    in_ready     <= 1'b1;
                    out_valid    <= 1'b0;
                    out_rdata    <= '0;
                    out_misalign <= 1'b0;
                    out_timeout  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060187_lsu.sv
// Scoreboarded bench: driver queues expected bus requests and completions, bus model and monitor check them.
module tb_ysyx_23060187_lsu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_rdata;
    logic        out_misalign;
    logic        out_timeout;

    ysyx_23060187_lsu #(.TIMEOUT_CYC(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_store    (in_is_store),
        .in_funct3      (in_funct3),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_rdata      (out_rdata),
        .out_misalign   (out_misalign),
        .out_timeout    (out_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int hs_cnt   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        tmo;
        int          cyc;
        string       name;
    } out_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        string       name;
    } req_exp_t;

    out_exp_t out_q[$];
    req_exp_t req_q[$];

    logic [31:0] bus_rdata  = '0;
    int          bus_delay  = 0;
    bit          bus_silent = 1'b0;
    bit          bus_stray  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Bus model: zero-wait request acceptance, response after bus_delay WAIT cycles.
    initial begin
        req_exp_t r;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = bus_stray;
            if (mem_req_valid && !rst) begin
                hs_cnt++;
                if (req_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_req: got request addr %h expected none", mem_addr);
                end else begin
                    r = req_q.pop_front();
                    chk({r.name, "_addr"}, mem_addr, r.addr);
                    chk({r.name, "_we"}, 32'(mem_we), 32'(r.we));
                    chk({r.name, "_wstrb"}, 32'(mem_wstrb), 32'(r.wstrb));
                    if (r.we) chk({r.name, "_wdata"}, mem_wdata, r.wdata);
                end
                mem_req_ready = 1'b1;
                @(negedge clk);
                mem_req_ready = 1'b0;
                if (!bus_silent) begin
                    repeat (bus_delay) @(negedge clk);
                    mem_resp_valid = 1'b1;
                    mem_rdata      = bus_rdata;
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        out_exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                done_cnt++;
                if (out_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got out_valid rdata %h expected none", out_rdata);
                end else begin
                    e = out_q.pop_front();
                    chk({e.name, "_rdata"}, out_rdata, e.rdata);
                    chk({e.name, "_misalign"}, 32'(out_misalign), 32'(e.mis));
                    chk({e.name, "_timeout"}, 32'(out_timeout), 32'(e.tmo));
                    chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 50 && done_cnt < target; i++) @(posedge clk);
        if (done_cnt < target) begin
            n_checks++;
            $display("FAIL %s_wait: got no out_valid expected one within 50 cycles", name);
        end
    endtask

    task automatic issue(input string name, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int lat, input logic [31:0] exp_rdata, input bit mis, input bit tmo,
                         input bit has_req, input logic [31:0] req_wdata, input logic [3:0] req_wstrb,
                         input logic [31:0] rdata, input int delay, input bit silent);
        out_exp_t e;
        req_exp_t r;
        int target;
        target = done_cnt + 1;
        @(negedge clk);
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        bus_rdata  = rdata;
        bus_delay  = delay;
        bus_silent = silent;
        if (has_req) begin
            r.addr  = {addr[31:2], 2'b00};
            r.we    = st;
            r.wdata = req_wdata;
            r.wstrb = req_wstrb;
            r.name  = name;
            req_q.push_back(r);
        end
        e.rdata = exp_rdata;
        e.mis   = mis;
        e.tmo   = tmo;
        e.cyc   = cyc + lat;
        e.name  = name;
        out_q.push_back(e);
        in_valid    = 1'b1;
        in_is_store = st;
        in_funct3   = f3;
        in_addr     = addr;
        in_wdata    = wdata;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(target, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end

    initial begin
        int hs0;
        int d0;
        req_exp_t r;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_is_store = 1'b0;
        in_funct3   = 3'b000;
        in_addr     = '0;
        in_wdata    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_out_flags", {30'd0, out_misalign, out_timeout}, 32'd0);
        rst = 1'b0;

        //     name       st f3      addr          wdata         lat exp_rdata     mis tmo req req_wdata     strb     rdata         dly sil
        issue("lw",       0, 3'b010, 32'h8000_0004, 32'h0,        5, 32'hDEAD_BEEF, 0, 0, 1, 32'h0,        4'h0,    32'hDEAD_BEEF, 2, 0);
        issue("lb3",      0, 3'b000, 32'h0000_1003, 32'h0,        3, 32'hFFFF_FF80, 0, 0, 1, 32'h0,        4'h0,    32'h8012_3456, 0, 0);
        issue("lbu3",     0, 3'b100, 32'h0000_1003, 32'h0,        3, 32'h0000_0080, 0, 0, 1, 32'h0,        4'h0,    32'h8012_3456, 0, 0);
        issue("lhu2",     0, 3'b101, 32'h0000_1002, 32'h0,        3, 32'h0000_8012, 0, 0, 1, 32'h0,        4'h0,    32'h8012_3456, 0, 0);
        issue("lh2",      0, 3'b001, 32'h0000_1002, 32'h0,        3, 32'hFFFF_8012, 0, 0, 1, 32'h0,        4'h0,    32'h8012_3456, 0, 0);
        issue("lb0",      0, 3'b000, 32'h0000_1000, 32'h0,        3, 32'h0000_0056, 0, 0, 1, 32'h0,        4'h0,    32'h8012_3456, 0, 0);
        issue("sb2",      1, 3'b000, 32'h0000_2002, 32'h0000_00AB, 3, 32'h0,        0, 0, 1, 32'hABAB_ABAB, 4'b0100, 32'h5555_5555, 0, 0);
        issue("sh2",      1, 3'b001, 32'h0000_2002, 32'h1234_CDEF, 3, 32'h0,        0, 0, 1, 32'hCDEF_CDEF, 4'b1100, 32'h0,        0, 0);
        issue("sw",       1, 3'b010, 32'h0000_2000, 32'hCAFE_F00D, 4, 32'h0,        0, 0, 1, 32'hCAFE_F00D, 4'hF,    32'h0,        1, 0);

        hs0 = hs_cnt;
        issue("lw_mis",   0, 3'b010, 32'h8000_0002, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0,        4'h0,    32'hFFFF_FFFF, 0, 0);
        chk("lw_mis_noreq", 32'(hs_cnt), 32'(hs0));
        issue("sh_mis",   1, 3'b001, 32'h0000_2001, 32'h1111_2222, 1, 32'h0,        1, 0, 0, 32'h0,        4'h0,    32'h0,        0, 0);
        issue("lhu3_mis", 0, 3'b101, 32'h0000_1003, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0,        4'h0,    32'h0,        0, 0);
        issue("ld_f3bad", 0, 3'b011, 32'h0000_1000, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0,        4'h0,    32'h0,        0, 0);
        issue("st_f3bad", 1, 3'b100, 32'h0000_1000, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0,        4'h0,    32'h0,        0, 0);

        issue("lw_tmo",   0, 3'b010, 32'h0000_3000, 32'h0,        TMO + 1, 32'h0,  0, 1, 1, 32'h0,        4'h0,    32'h1234_5678, 0, 1);

        // Stray response while idle must not produce a completion.
        d0 = done_cnt;
        bus_rdata = 32'hBAD0_BAD0;
        bus_stray = 1'b1;
        repeat (3) @(negedge clk);
        bus_stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_resp_ignored", 32'(done_cnt), 32'(d0));
        issue("lw_after", 0, 3'b010, 32'h0000_3004, 32'h0,        3, 32'h0BAD_F00D, 0, 0, 1, 32'h0,        4'h0,    32'h0BAD_F00D, 0, 0);

        // Reset while waiting on the bus abandons the access.
        @(negedge clk);
        bus_silent  = 1'b1;
        r.addr      = 32'h0000_4000;
        r.we        = 1'b0;
        r.wdata     = '0;
        r.wstrb     = 4'h0;
        r.name      = "lw_rst";
        req_q.push_back(r);
        in_valid    = 1'b1;
        in_is_store = 1'b0;
        in_funct3   = 3'b010;
        in_addr     = 32'h0000_4000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_in_ready", 32'(in_ready), 32'd1);
        chk("rstw_mem_outs", {mem_req_valid, mem_we, mem_wstrb, mem_addr[25:0]}, 32'd0);
        chk("rstw_out_outs", {out_valid, out_misalign, out_timeout, out_rdata[28:0]}, 32'd0);
        rst = 1'b0;
        issue("lw_post_rst", 0, 3'b010, 32'h0000_4008, 32'h0,     3, 32'h1357_9BDF, 0, 0, 1, 32'h0,        4'h0,    32'h1357_9BDF, 0, 0);

        repeat (4) @(negedge clk);
        chk("out_q_empty", 32'(out_q.size()), 32'd0);
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060187_lsu.md
# ysyx_23060187_lsu

Load/store unit sitting directly downstream of the EX-stage ALU: it takes the ALU-computed effective address plus store data and funct3, performs one word-bus memory transaction over a valid/ready handshake, and returns sign/zero-extended load data (or a store completion) to writeback. One access is in flight at a time. The unit detects misalignment and bus timeout.

## Interface
- TIMEOUT_CYC, 255: max cycles spent in REQ+WAIT before abort; range 1..65535.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EX offers an access
- in_ready  out  1  LSU accepts; high only in IDLE
- in_is_store  in  1  1 = store, 0 = load
- in_funct3  in  3  RV32I: 000 b, 001 h, 010 w, 100 bu, 101 hu (loads); 000/001/010 (stores)
- in_addr  in  32  effective address (ALU result)
- in_wdata  in  32  rs2 value for stores
- mem_req_valid  out  1  request pending
- mem_req_ready  in  1  bus accepts request
- mem_we  out  1  write request
- mem_addr  out  32  in_addr with [1:0] forced to 0
- mem_wdata  out  32  store data replicated to byte lanes
- mem_wstrb  out  4  byte enables; 0 for loads
- mem_resp_valid  in  1  read data / write ack
- mem_rdata  in  32  read word
- out_valid  out  1  one-cycle completion pulse
- out_rdata  out  32  extended load data; 0 for stores/errors
- out_misalign  out  1  with out_valid: access misaligned, no bus access made
- out_timeout  out  1  with out_valid: bus did not respond in time

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. On in_valid, latch is_store, funct3, addr[1:0], addr, wdata. If misaligned (h/hu with addr[0]=1; w with addr[1:0]≠0) or funct3 illegal for the access type -> DONE with misalign=1. Otherwise -> REQ.
- REQ: mem_req_valid=1, outputs stable until mem_req_ready; on handshake -> WAIT.
- WAIT: on mem_resp_valid, capture and extend mem_rdata (loads) -> DONE.
- DONE: out_valid=1 for exactly one cycle -> IDLE.
- Store lanes: sb wdata={4{b}}, wstrb=1<<addr[1:0]; sh wdata={2{h}}, wstrb=3<<addr[1:0]; sw wstrb=4'hF.
- Load extract: byte=rdata>>(8*addr[1:0]), half=rdata>>(8*addr[1:0]); b/h sign-extend, bu/hu zero-extend, w passthrough.
- Timeout: counter cleared on leaving IDLE, increments each cycle in REQ or WAIT; when it reaches TIMEOUT_CYC without a response -> DONE with timeout=1, req dropped. mem_resp_valid outside WAIT is ignored.
- Misalign and timeout are mutually exclusive; out_rdata=0 whenever either is set.

## Timing
- Reset: state IDLE, in_ready=1, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, out_valid=0, out_rdata=0, out_misalign=0, out_timeout=0, counter=0.
- Accept in cycle T -> mem_req_valid from T+1; zero-wait bus (req_ready at T+1, resp_valid at T+2) -> out_valid at T+3. Response never counted in the request-handshake cycle.
- Misaligned: accept at T -> out_valid at T+1, mem_req_valid never asserted.
- Timeout: out_valid exactly TIMEOUT_CYC+1 cycles after accept.
- Back-to-back: next accept possible in the cycle after out_valid.
- rst during REQ/WAIT: next cycle IDLE, all outputs at reset values; pending transaction abandoned.

## Structure
- Package ysyx_23060187_pkg: funct3 load/store encodings, state enum.
- Sub-module ysyx_23060187_lsu_align (combinational): store lane replication + wstrb, load extract/extend, misalign check.

## Test plan
- lw at 0x8000_0004, bus returns 0xDEAD_BEEF after 2 WAIT cycles -> mem_addr 0x8000_0004, wstrb 0, out_rdata 0xDEAD_BEEF, out_valid once.
- lb at offset 3, rdata 0x8012_3456 -> out_rdata 0xFFFF_FF80; lbu same -> 0x0000_0080; lhu offset 2 -> 0x0000_8012.
- sb 0x0000_00AB at offset 2 -> mem_we 1, wdata 0xABAB_ABAB, wstrb 4'b0100; sh offset 2 -> wstrb 4'b1100.
- lw at 0x...02 -> out_valid at T+1, out_misalign 1, no mem_req_valid.
- TIMEOUT_CYC=4, bus never responds -> out_valid with out_timeout 1 at T+5; later stray mem_resp_valid ignored.
- rst asserted in WAIT -> next cycle all outputs reset; following lw completes normally.
